rc4_keystream_gen: RTL and testbench

RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

---
 rtl/rc4_keystream_gen.sv | 190 +++++++++++++++++++
 tb/tb_rc4_keystream_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: key capture, S-box init, KSA, optional drop[n], and
// a one-word-per-cycle PRGA output stage with valid/ready flow control.
module rc4_keystream_gen #(
    parameter int WORD_W  = 8,
    parameter int KEY_MAX = 16,
    parameter int DROP_N  = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              key_valid,
    input  logic [WORD_W-1:0] key_data,
    input  logic              key_last,
    output logic              key_ready,
    input  logic              abort,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic              busy,
    output logic              key_err,
    output logic [31:0]       ks_count
);

    localparam int NENT = 2 ** WORD_W;
    localparam int KI_W = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int KL_W = $clog2(KEY_MAX + 1);
    localparam logic [WORD_W-1:0] IDX_LAST = '1;
    localparam logic [KL_W-1:0]   KEY_FULL = KL_W'(KEY_MAX);

    typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, GEN} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] i_q;
    logic [WORD_W-1:0] j_q;
    logic [KI_W-1:0]   kIdx_q;
    logic [KL_W-1:0]   keyLen_q;
    logic [31:0]       dropCnt_q;
    logic [WORD_W-1:0] ksData_q;
    logic              ksValid_q;
    logic              keyErr_q;
    logic [31:0]       ksCount_q;

    logic [WORD_W-1:0] sbox_q [NENT];
    logic [WORD_W-1:0] key_q  [KEY_MAX];

    logic [WORD_W-1:0] sIKsa;
    logic [WORD_W-1:0] sJKsa;
    logic [WORD_W-1:0] jKsa_d;
    logic [KI_W-1:0]   kIdx_d;
    logic [WORD_W-1:0] iPrga_d;
    logic [WORD_W-1:0] jPrga_d;
    logic [WORD_W-1:0] sIPrga;
    logic [WORD_W-1:0] sJPrga;
    logic [WORD_W-1:0] sumPrga;
    logic [WORD_W-1:0] word_d;

    logic stepOk;
    logic genLoad;
    logic initWr;
    logic ksaWr;
    logic prgaStep;
    logic keyWr;

    // Both the KSA and PRGA datapaths are evaluated every cycle; the state decides which one commits.
    always_comb begin
        sIKsa   = sbox_q[i_q];
        jKsa_d  = j_q + sIKsa + key_q[kIdx_q];
        sJKsa   = sbox_q[jKsa_d];
        kIdx_d  = (KL_W'(kIdx_q) == keyLen_q - KL_W'(1)) ? '0 : kIdx_q + KI_W'(1);

        iPrga_d = i_q + WORD_W'(1);
        sIPrga  = sbox_q[iPrga_d];
        jPrga_d = j_q + sIPrga;
        sJPrga  = sbox_q[jPrga_d];
        sumPrga = sIPrga + sJPrga;
        // The output word must come from the post-swap array, so the two swapped slots are forwarded.
        if (sumPrga == jPrga_d)
            word_d = sIPrga;
        else if (sumPrga == iPrga_d)
            word_d = sJPrga;
        else
            word_d = sbox_q[sumPrga];
    end

    assign stepOk   = !wb_rst_i && !abort;
    assign genLoad  = !ksValid_q || ks_ready;
    assign initWr   = stepOk && (state_q == INIT);
    assign ksaWr    = stepOk && (state_q == KSA);
    assign prgaStep = stepOk && ((state_q == DROP) || ((state_q == GEN) && genLoad));
    assign keyWr    = stepOk && (state_q == IDLE) && key_valid && (keyLen_q < KEY_FULL);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            kIdx_q    <= '0;
            keyLen_q  <= '0;
            dropCnt_q <= '0;
            ksData_q  <= '0;
            ksValid_q <= 1'b0;
            keyErr_q  <= 1'b0;
            ksCount_q <= '0;
        end else if (abort) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            kIdx_q    <= '0;
            keyLen_q  <= '0;
            dropCnt_q <= '0;
            ksValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        if (keyLen_q < KEY_FULL)
                            keyLen_q <= keyLen_q + KL_W'(1);
                        else
                            keyErr_q <= 1'b1;
                        if (key_last) begin
                            state_q   <= INIT;
                            i_q       <= '0;
                            j_q       <= '0;
                            keyErr_q  <= 1'b0;
                            ksCount_q <= '0;
                        end
                    end
                end
                INIT: begin
                    i_q <= i_q + WORD_W'(1);
                    if (i_q == IDX_LAST) begin
                        state_q <= KSA;
                        j_q     <= '0;
                        kIdx_q  <= '0;
                    end
                end
                KSA: begin
                    i_q    <= i_q + WORD_W'(1);
                    j_q    <= jKsa_d;
                    kIdx_q <= kIdx_d;
                    if (i_q == IDX_LAST) begin
                        j_q       <= '0;
                        dropCnt_q <= '0;
                        state_q   <= (DROP_N > 0) ? DROP : GEN;
                    end
                end
                DROP: begin
                    i_q       <= iPrga_d;
                    j_q       <= jPrga_d;
                    dropCnt_q <= dropCnt_q + 32'd1;
                    if ((dropCnt_q + 32'd1) == 32'(DROP_N))
                        state_q <= GEN;
                end
                GEN: begin
                    if (ksValid_q && ks_ready)
                        ksCount_q <= ksCount_q + 32'd1;
                    if (genLoad) begin
                        i_q       <= iPrga_d;
                        j_q       <= jPrga_d;
                        ksData_q  <= word_d;
                        ksValid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // S-box and key storage carry no reset; INIT rewrites every S-box entry before it is read.
    always_ff @(posedge wb_clk_i) begin
        if (initWr) begin
            sbox_q[i_q] <= i_q;
        end else if (ksaWr) begin
            sbox_q[i_q]    <= sJKsa;
            sbox_q[jKsa_d] <= sIKsa;
        end else if (prgaStep) begin
            sbox_q[iPrga_d] <= sJPrga;
            sbox_q[jPrga_d] <= sIPrga;
        end
        if (keyWr)
            key_q[keyLen_q[KI_W-1:0]] <= key_data;
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q == INIT) || (state_q == KSA) || (state_q == DROP);
    assign ks_data   = ksData_q;
    assign ks_valid  = ksValid_q;
    assign key_err   = keyErr_q;
    assign ks_count  = ksCount_q;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Drives three generator instances (default, drop-3, 4-word key limit) with shared
// stimulus and checks each against a plain software RC4 model every cycle.
module tb_rc4_keystream_gen;

    localparam int NEXP = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       keyValid;
    logic       keyLast;
    logic       abortIn;
    logic       ksReady;
    logic [7:0] keyData;

    logic        keyReady [3];
    logic        ksValid  [3];
    logic        busy     [3];
    logic        keyErr   [3];
    logic [7:0]  ksData   [3];
    logic [31:0] ksCount  [3];

    rc4_keystream_gen #(.WORD_W(8), .KEY_MAX(16), .DROP_N(0)) dutA (
        .wb_clk_i(clk), .wb_rst_i(rst), .key_valid(keyValid), .key_data(keyData),
        .key_last(keyLast), .key_ready(keyReady[0]), .abort(abortIn), .ks_data(ksData[0]),
        .ks_valid(ksValid[0]), .ks_ready(ksReady), .busy(busy[0]), .key_err(keyErr[0]),
        .ks_count(ksCount[0])
    );

    rc4_keystream_gen #(.WORD_W(8), .KEY_MAX(16), .DROP_N(3)) dutB (
        .wb_clk_i(clk), .wb_rst_i(rst), .key_valid(keyValid), .key_data(keyData),
        .key_last(keyLast), .key_ready(keyReady[1]), .abort(abortIn), .ks_data(ksData[1]),
        .ks_valid(ksValid[1]), .ks_ready(ksReady), .busy(busy[1]), .key_err(keyErr[1]),
        .ks_count(ksCount[1])
    );

    rc4_keystream_gen #(.WORD_W(8), .KEY_MAX(4), .DROP_N(0)) dutC (
        .wb_clk_i(clk), .wb_rst_i(rst), .key_valid(keyValid), .key_data(keyData),
        .key_last(keyLast), .key_ready(keyReady[2]), .abort(abortIn), .ks_data(ksData[2]),
        .ks_valid(ksValid[2]), .ks_ready(ksReady), .busy(busy[2]), .key_err(keyErr[2]),
        .ks_count(ksCount[2])
    );

    int checks = 0;
    int errors = 0;

    int         keyBuf [16];
    int         keyLenBuf;
    logic [7:0] expW [3][NEXP];
    logic [7:0] lit  [3][10];
    int         litLen [3];
    logic       expKeyErr [3];
    bit         checkMode;
    bit         idleExp;
    bit         resetExp;
    bit         stallMode;
    int         loadGen;

    int         lastGen = 0;
    int         latCnt = 0;
    int         expIdx [3];
    int         hs [3];
    bit         latDone [3];
    bit         prevValid [3];
    bit         prevReady;
    logic [7:0] prevData [3];

    function automatic int dropOf(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int keyMaxOf(input int k);
        return (k == 2) ? 4 : 16;
    endfunction

    // Textbook RC4 on integer arrays: KSA over the effective key, then drop and generate.
    task automatic buildModel(input int k);
        int s [256];
        int i, j, t, effLen, dropN;
        effLen = (keyLenBuf > keyMaxOf(k)) ? keyMaxOf(k) : keyLenBuf;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + keyBuf[n % effLen]) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        dropN = dropOf(k);
        for (int n = 0; n < dropN + NEXP; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (n >= dropN) expW[k][n - dropN] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s dut%0d got %0h expected %0h", name, k, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetExp) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("reset_key_ready", k, 32'(keyReady[k]), 32'd1);
                checkOutput("reset_ks_valid", k, 32'(ksValid[k]), 32'd0);
                checkOutput("reset_ks_data", k, 32'(ksData[k]), 32'd0);
                checkOutput("reset_busy", k, 32'(busy[k]), 32'd0);
                checkOutput("reset_key_err", k, 32'(keyErr[k]), 32'd0);
                checkOutput("reset_ks_count", k, ksCount[k], 32'd0);
            end
        end
        if (idleExp) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("idle_key_ready", k, 32'(keyReady[k]), 32'd1);
                checkOutput("idle_busy", k, 32'(busy[k]), 32'd0);
                checkOutput("idle_ks_valid", k, 32'(ksValid[k]), 32'd0);
                checkOutput("idle_key_err", k, 32'(keyErr[k]), 32'(expKeyErr[k]));
            end
        end
        if (checkMode) begin
            if (loadGen != lastGen) begin
                lastGen = loadGen;
                latCnt = 0;
                for (int k = 0; k < 3; k++) begin
                    expIdx[k] = 0;
                    hs[k] = 0;
                    latDone[k] = 1'b0;
                    prevValid[k] = 1'b0;
                    for (int n = 0; n < litLen[k]; n++)
                        checkOutput("model_pin", k, 32'(expW[k][n]), 32'(lit[k][n]));
                end
            end else begin
                latCnt++;
            end
            for (int k = 0; k < 3; k++) begin
                checkOutput("busy", k, 32'(busy[k]), 32'(latCnt < 512 + dropOf(k)));
                checkOutput("key_ready", k, 32'(keyReady[k]), 32'd0);
                checkOutput("ks_count", k, ksCount[k], 32'(hs[k]));
                if (!latDone[k]) begin
                    if (ksValid[k]) begin
                        checkOutput("latency", k, 32'(latCnt), 32'(513 + dropOf(k)));
                        latDone[k] = 1'b1;
                    end else if (latCnt > 540) begin
                        checkOutput("latency_timeout", k, 32'(latCnt), 32'(513 + dropOf(k)));
                        latDone[k] = 1'b1;
                    end
                end
                if (prevValid[k] && !prevReady) begin
                    checkOutput("stall_valid", k, 32'(ksValid[k]), 32'd1);
                    checkOutput("stall_data", k, 32'(ksData[k]), 32'(prevData[k]));
                end
                if (ksValid[k] && ksReady) begin
                    if (expIdx[k] < NEXP)
                        checkOutput("ks_data", k, 32'(ksData[k]), 32'(expW[k][expIdx[k]]));
                    expIdx[k]++;
                    hs[k]++;
                end
                prevValid[k] = ksValid[k];
                prevData[k] = ksData[k];
            end
            prevReady = ksReady;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ksReady = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic setKey(input int len, input logic [127:0] v);
        keyLenBuf = len;
        for (int i = 0; i < len; i++) keyBuf[i] = int'(v[127 - 8 * i -: 8]);
        for (int k = 0; k < 3; k++) litLen[k] = 0;
    endtask

    task automatic setLit(input int k, input int n, input logic [79:0] v);
        litLen[k] = n;
        for (int i = 0; i < n; i++) lit[k][i] = v[79 - 8 * i -: 8];
    endtask

    // Streams the buffered key back-to-back; the model is built on the key_last handshake.
    task automatic applyStimulus();
        for (int w = 0; w < keyLenBuf; w++) begin
            keyValid = 1'b1;
            keyData  = 8'(keyBuf[w]);
            keyLast  = (w == keyLenBuf - 1);
            tick();
            if (w == keyLenBuf - 1) begin
                keyValid = 1'b0;
                keyLast  = 1'b0;
                idleExp  = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    buildModel(k);
                    expKeyErr[k] = 1'b0;
                end
                loadGen++;
                checkMode = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) expKeyErr[k] = ((w + 1) > keyMaxOf(k));
            end
        end
    endtask

    task automatic doAbort();
        checkMode = 1'b0;
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        idleExp = 1'b1;
    endtask

    task automatic doReset();
        checkMode = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resetExp = 1'b1;
        idleExp = 1'b1;
        for (int k = 0; k < 3; k++) expKeyErr[k] = 1'b0;
        tick();
        resetExp = 1'b0;
    endtask

    task automatic setKeyLits();
        setKey(3, {24'h4B6579, 104'h0});
        setLit(0, 10, 80'hEB9F7781B734CA72A719);
        setLit(1, 3, {24'h81B734, 56'h0});
        setLit(2, 10, 80'hEB9F7781B734CA72A719);
    endtask

    initial begin
        rst = 1'b1;
        keyValid = 1'b0;
        keyLast = 1'b0;
        keyData = '0;
        abortIn = 1'b0;
        ksReady = 1'b1;
        checkMode = 1'b0;
        idleExp = 1'b0;
        resetExp = 1'b0;
        stallMode = 1'b0;
        loadGen = 0;
        for (int k = 0; k < 3; k++) begin
            expKeyErr[k] = 1'b0;
            litLen[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        resetExp = 1'b1;
        idleExp = 1'b1;
        tick();
        resetExp = 1'b0;

        setKeyLits();
        applyStimulus();
        runCycles(560);

        doAbort();
        setKey(4, {32'h57696B69, 96'h0});
        setLit(0, 6, {48'h6044DB6D41B7, 32'h0});
        setLit(2, 6, {48'h6044DB6D41B7, 32'h0});
        applyStimulus();
        runCycles(560);

        doAbort();
        setKey(6, {48'h536563726574, 80'h0});
        setLit(0, 8, {64'h04D46B053CA87B59, 16'h0});
        applyStimulus();
        runCycles(560);

        doAbort();
        stallMode = 1'b1;
        setKeyLits();
        applyStimulus();
        runCycles(900);
        stallMode = 1'b0;

        doAbort();
        setKeyLits();
        applyStimulus();
        runCycles(300);
        doAbort();
        runCycles(3);

        setKeyLits();
        applyStimulus();
        runCycles(540);
        doReset();
        setKeyLits();
        applyStimulus();
        runCycles(560);

        stallMode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            doAbort();
            setKey($urandom_range(1, 16), '0);
            for (int i = 0; i < keyLenBuf; i++) keyBuf[i] = $urandom_range(0, 255);
            applyStimulus();
            runCycles(860);
        end
        stallMode = 1'b0;
        checkMode = 1'b0;
        idleExp = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
